spi_pixel_writer: RTL and testbench
===================================

Name: spi_pixel_writer

Overview:
- Sits directly downstream of the SPI byte receiver and carries each received byte from the SPI clock domain into the system clock domain.
- Assembles the bytes into one raster-ordered grayscale frame and writes each pixel into the frame-buffer BRAM.
- Tracks row and column for the downstream convolution stage.
- Signals frame completion, and holds the frame until the edge-detection core acknowledges it.

Parameters:
- IMG_WIDTH, 160, pixels per row
- IMG_HEIGHT, 120, rows per frame
- PIX_W, 8, bits per pixel; equals the SPI message width
- ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT), frame-buffer address width

Ports:
- clk  input  1  system clock; must run at 4× or more the SPI clock frequency
- nreset  input  1  reset, asynchronous, active-low
- spi_byte  input  PIX_W  received byte, from the SPI clock domain; stable while spi_byte_valid is high
- spi_byte_valid  input  1  SPI-domain byte-ready level; high for one SPI clock period per byte
- frame_ack  input  1  single-cycle pulse from the core: frame consumed, buffer may be refilled
- wr_en  output  1  frame-buffer write strobe, one cycle per pixel
- wr_addr  output  ADDR_W  frame-buffer write address
- wr_data  output  PIX_W  pixel value
- row  output  $clog2(IMG_HEIGHT)  row of the current or next pixel
- col  output  $clog2(IMG_WIDTH)  column of the current or next pixel
- row_done  output  1  single-cycle pulse when the last pixel of a row is written
- frame_ready  output  1  level: the complete frame is in the buffer
- busy  output  1  level: a frame is partially loaded
- overrun  output  1  sticky flag: a byte arrived while frame_ready was high and was dropped

Behaviour:
- Reset (asynchronous, while nreset is low):
  - All outputs are 0 and all counters are 0.
  - State is IDLE and the synchronizer flops are cleared.
  - Asserting reset mid-frame discards the partial frame; the next byte after release is pixel 0.
- CDC:
  - spi_byte_valid passes through a 2-flop synchronizer, then a third register.
  - byte_evt = s2 & ~s3 (rising-edge detect), giving exactly one event per SPI byte.
  - On a byte_evt cycle, spi_byte is sampled directly. It is safe because the data is held stable for the whole valid period.
  - Only spi_byte_valid is synchronized; the multi-bit bus is never synchronized.
- Latency:
  - wr_en/wr_addr/wr_data are registered and asserted in the cycle after byte_evt.
  - That is 3–4 clk cycles after the spi_byte_valid rising edge, depending on phase.
- State machine (states IDLE, LOAD, FULL):
  - IDLE: busy=0, frame_ready=0, address 0. On byte_evt, write pixel 0 and go to LOAD (or to FULL if the frame is 1 pixel).
  - LOAD: busy=1. On each byte_evt, write the pixel at the current address, then increment the address and col.
    - When col = IMG_WIDTH-1, col wraps to 0, row increments, and row_done pulses with that write's wr_en.
    - On the write at address IMG_WIDTH*IMG_HEIGHT-1, go to FULL. Address, row and col wrap to 0.
  - FULL: frame_ready=1, busy=0, no writes.
    - byte_evt without frame_ack: the byte is dropped and overrun is set.
    - frame_ack: clear frame_ready and overrun, then go to IDLE.
- Simultaneous events:
  - frame_ack and byte_evt in the same cycle while in FULL: ack wins. The byte is written as pixel 0 at address 0, overrun stays 0, and the next state is LOAD.
  - frame_ack in IDLE or LOAD is ignored.
- Frame continuity: a frame may span any number of SPI transactions. Chip-select gaps do not affect the address.
- Arithmetic:
  - The address counter is ADDR_W bits and is compared against IMG_WIDTH*IMG_HEIGHT-1, so it never exceeds the frame size.
  - row and col are maintained as separate counters. They are never derived by division.
- Outputs are held between writes:
  - wr_addr/wr_data hold their last written values while wr_en=0.
  - row/col show the position of the next pixel.

Decomposition:
- Package edge_pkg holds:
  - the state enum pixel_wr_state_t {IDLE, LOAD, FULL};
  - default image dimensions IMG_WIDTH_DEF=160, IMG_HEIGHT_DEF=120 and PIX_W_DEF=8.
- One sub-module, pulse_sync: the 2-flop synchronizer plus rising-edge detect with asynchronous active-low reset. It is reusable for other SPI-domain strobes.
- The address, row and column counters and the FSM stay in spi_pixel_writer.

Test Plan:
1. Single byte 0xA5, clk 50 MHz, SPI 5 MHz → wr_en once at wr_addr=0 with wr_data=0xA5 within 4 clk of the valid rise; busy=1.
2. IMG_WIDTH=4, IMG_HEIGHT=2, bytes 0x00–0x07 → addresses 0–7 written in order; row_done on pixels 3 and 7; frame_ready=1 after pixel 7; row and col back to 0.
3. Full frame, then 2 extra bytes, then frame_ack → no wr_en for the extras; overrun=1 until the ack; after the ack, frame_ready=0, overrun=0, state IDLE.
4. frame_ack coincident with byte_evt in FULL → wr_en at wr_addr=0 with that byte; overrun=0; busy=1.
5. nreset pulsed low after pixel 5 of 8 → all outputs 0; the next byte 0x3C is written at wr_addr=0.
6. Bytes split across 3 transactions with idle valid-low gaps of 20 SPI clocks → addresses continue contiguously with no duplicates or skips.

Source files
------------

// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
// edge_pkg : shared types and default dimensions for the edge-detect front end
// Revision : 1.0
// ============================================================================
package edge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } pixel_wr_state_t;

   localparam int IMG_WIDTH_DEF  = 160;
   localparam int IMG_HEIGHT_DEF = 120;
   localparam int PIX_W_DEF      = 8;

endpackage
`default_nettype wire

// File: rtl/pulse_sync.sv
`default_nettype none
// ============================================================================
// pulse_sync : 2-flop synchronizer plus rising-edge detect for a slow strobe
// Revision   : 1.0
// ============================================================================
module pulse_sync (
   input  logic clk,
   input  logic nreset,
   input  logic async_i,
   output logic pulse_o
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= async_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign pulse_o = s2_q & ~s3_q;

endmodule
`default_nettype wire

// File: rtl/spi_pixel_writer.sv
`default_nettype none
// ============================================================================
// spi_pixel_writer : moves SPI bytes into the clk domain and writes one
//                    raster-ordered grayscale frame into the frame buffer
// Revision         : 1.0
// ============================================================================
module spi_pixel_writer
   import edge_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter int PIX_W      = PIX_W_DEF,
   parameter int ADDR_W     = $clog2(IMG_WIDTH*IMG_HEIGHT),
   parameter int ROW_W      = $clog2(IMG_HEIGHT),
   parameter int COL_W      = $clog2(IMG_WIDTH)
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic [PIX_W-1:0]  spi_byte,
   input  logic              spi_byte_valid,
   input  logic              frame_ack,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PIX_W-1:0]  wr_data,
   output logic [ROW_W-1:0]  row,
   output logic [COL_W-1:0]  col,
   output logic              row_done,
   output logic              frame_ready,
   output logic              busy,
   output logic              overrun
);

   localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(IMG_WIDTH*IMG_HEIGHT-1);
   localparam logic [COL_W-1:0]  C_LAST_COL  = COL_W'(IMG_WIDTH-1);

   logic byte_evt;

   pulse_sync u_valid_sync (
      .clk     (clk),
      .nreset  (nreset),
      .async_i (spi_byte_valid),
      .pulse_o (byte_evt)
   );

   pixel_wr_state_t   state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [PIX_W-1:0]  wr_data_q, wr_data_d;
   logic              row_done_q, row_done_d;
   logic              overrun_q, overrun_d;
   logic              do_write;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         row_done_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         row_q      <= row_d;
         col_q      <= col_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         row_done_q <= row_done_d;
         overrun_q  <= overrun_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      row_d      = row_q;
      col_d      = col_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      row_done_d = 1'b0;
      overrun_d  = overrun_q;
      do_write   = 1'b0;

      case (state_q)
         IDLE, LOAD: do_write = byte_evt;
         FULL: begin
            // An ack releases the buffer even if a byte lands in the same cycle.
            if (frame_ack) begin
               overrun_d = 1'b0;
               state_d   = IDLE;
               do_write  = byte_evt;
            end else if (byte_evt) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_write) begin
         wr_en_d   = 1'b1;
         wr_addr_d = addr_q;
         wr_data_d = spi_byte;
         if (col_q == C_LAST_COL) begin
            col_d      = '0;
            row_d      = row_q + ROW_W'(1);
            row_done_d = 1'b1;
         end else begin
            col_d = col_q + COL_W'(1);
         end
         if (addr_q == C_LAST_ADDR) begin
            state_d = FULL;
            addr_d  = '0;
            row_d   = '0;
            col_d   = '0;
         end else begin
            state_d = LOAD;
            addr_d  = addr_q + ADDR_W'(1);
         end
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign row         = row_q;
   assign col         = col_q;
   assign row_done    = row_done_q;
   assign frame_ready = (state_q == FULL);
   assign busy        = (state_q == LOAD);
   assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_pixel_writer.sv
`default_nettype none
// ============================================================================
// tb_spi_pixel_writer : directed/random bench for a 4x2 frame
// Revision            : 1.0
// ============================================================================
module tb_spi_pixel_writer;

   localparam int W = 4;
   localparam int H = 2;
   localparam int N = W * H;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic [7:0] spi_byte = 8'h00;
   logic       spi_byte_valid = 1'b0;
   logic       frame_ack = 1'b0;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic       row;
   logic [1:0] col;
   logic       row_done;
   logic       frame_ready;
   logic       busy;
   logic       overrun;

   spi_pixel_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
      .clk            (clk),
      .nreset         (nreset),
      .spi_byte       (spi_byte),
      .spi_byte_valid (spi_byte_valid),
      .frame_ack      (frame_ack),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .row            (row),
      .col            (col),
      .row_done       (row_done),
      .frame_ready    (frame_ready),
      .busy           (busy),
      .overrun        (overrun)
   );

   // 50 MHz system clock; one SPI period (5 MHz) is 10 clk cycles
   always #10 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: next pixel index, buffer-full flag, overrun flag
   int m_idx  = 0;
   bit m_full = 1'b0;
   bit m_ovr  = 1'b0;

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, "_row"},   int'(row),         m_full ? 0 : m_idx / W);
      check({tag, "_col"},   int'(col),         m_full ? 0 : m_idx % W);
      check({tag, "_ready"}, int'(frame_ready), int'(m_full));
      check({tag, "_busy"},  int'(busy),        int'(!m_full && m_idx != 0));
      check({tag, "_ovr"},   int'(overrun),     int'(m_ovr));
   endtask

   task automatic send(input logic [7:0] b, input bit ack_with, input string tag);
      bit         exp_wr;
      int         exp_addr = 0;
      bit         exp_rd = 1'b0;
      int         seen = 0;
      int         first = -1;
      int         gaddr = 0;
      logic [7:0] gdata = 8'h00;
      bit         grd = 1'b0;
      if (m_full && ack_with) begin
         m_full = 1'b0;
         m_ovr  = 1'b0;
      end
      exp_wr = !m_full;
      if (exp_wr) begin
         exp_addr = m_idx;
         exp_rd   = (m_idx % W) == W - 1;
         m_idx++;
         if (m_idx == N) begin
            m_idx  = 0;
            m_full = 1'b1;
         end
      end else begin
         m_ovr = 1'b1;
      end
      @(posedge clk); #1;
      spi_byte       = b;
      spi_byte_valid = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         if (wr_en) begin
            seen++;
            if (first < 0) begin
               first = k;
               gaddr = int'(wr_addr);
               gdata = wr_data;
               grd   = row_done;
            end
         end
         // byte event is present after the second edge; the ack overlaps it
         if (k == 2 && ack_with) frame_ack = 1'b1;
         if (k == 3) frame_ack = 1'b0;
         if (k == 10) spi_byte_valid = 1'b0;
      end
      check({tag, "_wrcount"}, seen, int'(exp_wr));
      if (exp_wr) begin
         check({tag, "_latency"}, int'(first >= 1 && first <= 4), 1);
         check({tag, "_addr"},    gaddr, exp_addr);
         check({tag, "_data"},    int'(gdata), int'(b));
         check({tag, "_rowdone"}, int'(grd), int'(exp_rd));
      end
      check_status(tag);
   endtask

   task automatic ack_pulse(input string tag);
      @(posedge clk); #1;
      frame_ack = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0;
      if (m_full) begin
         m_full = 1'b0;
         m_ovr  = 1'b0;
      end
      @(posedge clk); #1;
      check_status(tag);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk); #3;
      nreset = 1'b0;
      #5;
      m_idx  = 0;
      m_full = 1'b0;
      m_ovr  = 1'b0;
      check({tag, "_wr_en"},   int'(wr_en),    0);
      check({tag, "_wr_addr"}, int'(wr_addr),  0);
      check({tag, "_wr_data"}, int'(wr_data),  0);
      check({tag, "_rowdone"}, int'(row_done), 0);
      check_status(tag);
      @(posedge clk); #1;
      nreset = 1'b1;
   endtask

   initial begin
      // Reset state
      #15;
      do_reset("rst0");

      // Single byte 0xA5
      send(8'hA5, 1'b0, "single");

      // Rest of the frame with random pixels, then two dropped bytes
      for (int i = 0; i < N - 1; i++) send(8'($urandom), 1'b0, "fill1");
      send(8'($urandom), 1'b0, "extra1");
      send(8'($urandom), 1'b0, "extra2");
      ack_pulse("ack_full");

      // Full frame, then ack coincident with the next byte
      for (int i = 0; i < N; i++) send(8'($urandom), 1'b0, "fill2");
      send(8'($urandom), 1'b1, "ack_coinc");

      // Ack while loading is ignored
      ack_pulse("ack_load");
      send(8'($urandom), 1'b0, "after_ack_load");

      // Reset mid-frame after pixel 5, next byte lands at address 0
      do_reset("rst1");
      for (int i = 0; i < 6; i++) send(8'($urandom), 1'b0, "pre_rst");
      do_reset("rst_mid");
      send(8'h3C, 1'b0, "post_rst");

      // Three transactions separated by 20 SPI clocks of idle
      do_reset("rst2");
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, "gap");
         repeat (200) @(posedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
